dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Controller between the pipeline MEM stage, a word-only program/debug loader port, and the single-port word-addressed data memory (`DM`). It arbitrates the two requesters and sequences each access over multiple cycles, including read-modify-write for byte/halfword stores. It performs RV32I load lane extraction with sign/zero extension and flags misaligned or illegal accesses. The pipeline stalls on `a_stall` while its request is outstanding.

## Interface
Parameters: none. The memory depth is fixed by `DM` at 256 words.

Ports (clock and reset first):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_req` in 1: pipeline request; held with its fields stable until `a_ack`.
- `a_we` in 1: 1 = store, 0 = load.
- `a_funct3` in 3: RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `a_addr` in 32: byte address.
- `a_wdata` in 32: store data, right-aligned.
- `a_ack` out 1: one-cycle completion pulse.
- `a_err` out 1: valid with `a_ack`; 1 = misaligned or illegal `funct3`.
- `a_rdata` out 32: load result; registered and held until the next port-A completion.
- `a_stall` out 1: `a_req & ~a_ack`.
- `b_req`, `b_we` in 1: loader request and direction. Word-only; `b_addr[1:0]` ignored.
- `b_addr`, `b_wdata` in 32: loader address and data.
- `b_ack` out 1: loader completion pulse.
- `b_rdata` out 32: registered and held.
- `dm_memRead`, `dm_memWrite` out 1: to DM `memRead`/`memWrite`.
- `dm_addr` out 32: word-aligned byte address (`[1:0]` = 0).
- `dm_writeData` out 32: to DM `writeData`.
- `dm_readData` in 32: from DM `readData`. Combinational in the same cycle as `dm_memRead`.

## Operation
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- **IDLE**
  - If any request is present, grant one and latch owner, address, `we`, `funct3` and wdata.
  - Port B always goes to ACCESS.
  - Port A goes to RESP with error if misaligned or illegal: halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or `funct3` ∈ {011, 110, 111}.
  - Otherwise port A goes to RMW_RD for SB/SH and to ACCESS for all loads and SW.
- **Arbitration:** round-robin. A `last_grant` register resets to B, so A wins the first tie. The grant flips priority to the other port. A lone requester is always granted.
- **ACCESS:** load drives `dm_memRead` and captures `dm_readData`; SW drives `dm_memWrite` with the latched data. Next state is RESP.
- **RMW_RD:** `dm_memRead`; capture the word. Next state is RMW_WR.
- **RMW_WR:** `dm_memWrite` with the merged word. Next state is RESP.
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half `addr[1]` with `wdata[15:0]`.
- **Load extraction:**
  - LB/LBU select byte `addr[1:0]`.
  - LH/LHU select half `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Port B returns the raw word.
- **RESP:**
  - Pulse the owner's ack.
  - Update the owner's rdata. On error, rdata = 0 and `a_err` = 1.
  - Next state is IDLE.
- The error path issues no DM read or write.
- Addresses ≥ 0x400 are passed through unchecked; DM aliases them.
- DM control outputs decode from registered state only. There is no combinational path from `*_req` to `dm_*`.

## Timing
- Reset values:
  - State IDLE, `last_grant` = B.
  - All outputs 0: `a_ack`, `b_ack`, `a_err`, `a_rdata`, `b_rdata`, `dm_memRead`, `dm_memWrite`, `dm_addr`, `dm_writeData`.
  - `a_stall` follows `a_req`.
- Request first sampled in IDLE at edge k:
  - Load, SW, and port-B access: ack high during cycle k+2.
  - SB/SH: ack high during cycle k+3.
  - Error: ack high during cycle k+1.
- The requester must deassert, or present a new request, in the cycle after ack. A request still high in IDLE is treated as new.
- Throughput is one access per 3 cycles (4 for a sub-word store).
- Requests arriving outside IDLE wait. There is no preemption.
- Reset mid-operation (any state):
  - Return to IDLE immediately.
  - `dm_memWrite` drops asynchronously, so no write completes after reset asserts.
  - No ack is issued for the aborted request.

## Structure
- Package `dm_pkg`:
  - `funct3` constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `dm_state_t`.
  - Owner enum `dm_owner_t` {OWN_A, OWN_B}.
- One sub-module, `dm_lane_align` (combinational):
  - Inputs: `funct3`, `addr[1:0]`, raw word, store data.
  - Outputs: extended load value and merged store word.
- FSM, arbiter and registers live in `dm_access_ctrl`.

## Test plan
- **Reset:** all outputs 0. After release, A and B requesting together: A acked first, B second.
- **Word round trip:** A SW 0x10 ← 0xDEADBEEF, then LW 0x10. Expect `a_rdata` = 0xDEADBEEF, ack at k+2, exactly one `dm_memWrite` cycle.
- **Byte store, then sub-word loads:**
  - SB 0x11 ← 0x000000AA onto 0xDEADBEEF; the word becomes 0xDEADAAEF.
  - LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA; LH 0x12 → 0xFFFFDEAD.
  - SB ack at k+3.
- **Errors:**
  - LW 0x12 → `a_err` = 1, `a_rdata` = 0, ack at k+1, no `dm_memRead`/`dm_memWrite`.
  - `funct3` = 011 → same response.
- **Fairness:** A and B both held requesting for 6 grants. Grants alternate A, B, A, B, A, B; `a_stall` is high except in A's ack cycles.
- **Reset mid-RMW:** SB 0x20 with reset asserted in RMW_RD. Expect no `dm_memWrite`, the word unchanged, and no `a_ack`.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: RV32I width codes,
// FSM state and requester-owner encodings, and the access legality helpers.
// Latency: none (types and pure functions only). Backpressure: n/a.
package dm_pkg;

  // RV32I funct3 width codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } dm_state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } dm_owner_t;

  // funct3 codes that name no RV32I load/store width
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
           ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between a 32-bit memory word and RV32I sub-word accesses.
// Latency: purely combinational. Backpressure: none, follows its inputs.
// Ports: funct3/addr_lo select the lane; raw_word is the memory word, store_data
// the right-aligned store value; load_val is the extended load result and
// store_word the raw word with the store lane(s) replaced.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Load extraction: signed codes replicate the lane MSB, unsigned pad zeros.
  always_comb begin
    load_val = raw_word;
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h000000, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0000, half_sel};
      default: load_val = raw_word;
    endcase
  end

  // Store merge: only the addressed lane(s) change, the rest of the word is kept.
  always_comb begin
    store_word = raw_word;
    case (funct3[1:0])
      2'b00: store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      2'b01: begin
        if (addr_lo[1]) begin
          store_word[31:16] = store_data[15:0];
        end else begin
          store_word[15:0] = store_data[15:0];
        end
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Arbitrates pipeline port A and word-only loader port B onto single-port data memory DM.
// Latency: ack 2 cycles after grant for loads/SW/port B, 3 for SB/SH, 1 for a faulting access.
// Backpressure: one access in flight; a requester holds its fields until ack, A sees a_stall.
// Ports: clk/rst; port A (a_req/a_we/a_funct3/a_addr/a_wdata -> a_ack/a_err/a_rdata/a_stall);
// port B (b_req/b_we/b_addr/b_wdata -> b_ack/b_rdata); DM side (dm_memRead/dm_memWrite/
// dm_addr/dm_writeData out, dm_readData in, combinational read in the same cycle).
module dm_access_ctrl
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // pipeline MEM stage
  input  logic        a_req,
  input  logic        a_we,
  input  logic [2:0]  a_funct3,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  output logic        a_stall,
  // program/debug loader
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  // data memory
  output logic        dm_memRead,
  output logic        dm_memWrite,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_writeData,
  input  logic [31:0] dm_readData
);

  dm_state_t   state_q, state_d;
  dm_owner_t   owner_q, owner_d;
  dm_owner_t   last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        a_err_q, a_err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        grant_a;
  logic        a_bad;
  logic [31:0] lane_raw;
  logic [31:0] load_val;
  logic [31:0] store_word;

  // During RMW_WR the merge works on the word captured in RMW_RD; otherwise
  // the lane logic looks straight at the memory read data for load extraction.
  assign lane_raw = (state_q == RMW_WR) ? word_q : dm_readData;

  dm_lane_align u_lane (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .raw_word   (lane_raw),
    .store_data (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    a_bad = f3_illegal(a_funct3) || f3_misaligned(a_funct3, a_addr[1:0]);
    // Round-robin: on a tie the port that did not win last time goes first.
    grant_a = a_req && (!b_req || (last_grant_q == OWN_B));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          if (grant_a) begin
            owner_d      = OWN_A;
            last_grant_d = OWN_A;
            addr_d       = a_addr;
            we_d         = a_we;
            funct3_d     = a_funct3;
            wdata_d      = a_wdata;
            if (a_bad) begin
              // Faulting access skips the memory entirely and answers at once.
              state_d   = RESP;
              a_ack_d   = 1'b1;
              a_err_d   = 1'b1;
              a_rdata_d = 32'h0;
            end else if (a_we && !a_funct3[1]) begin
              state_d = RMW_RD;
            end else begin
              state_d = ACCESS;
            end
          end else begin
            owner_d      = OWN_B;
            last_grant_d = OWN_B;
            addr_d       = b_addr;
            we_d         = b_we;
            funct3_d     = F3_W;
            wdata_d      = b_wdata;
            state_d      = ACCESS;
          end
        end
      end

      ACCESS: begin
        state_d = RESP;
        // Acks and read data are registered on entry to RESP so that they
        // are valid together for exactly the RESP cycle.
        if (owner_q == OWN_A) begin
          a_ack_d = 1'b1;
          if (!we_q) begin
            a_rdata_d = load_val;
          end
        end else begin
          b_ack_d = 1'b1;
          if (!we_q) begin
            b_rdata_d = dm_readData;
          end
        end
      end

      RMW_RD: begin
        word_d  = dm_readData;
        state_d = RMW_WR;
      end

      RMW_WR: begin
        // Only port A issues sub-word stores.
        state_d = RESP;
        a_ack_d = 1'b1;
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_A;
      last_grant_q <= OWN_B;
      addr_q       <= 32'h0;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      wdata_q      <= 32'h0;
      word_q       <= 32'h0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      a_rdata_q    <= 32'h0;
      b_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_err_q      <= a_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Memory strobes decode only from flopped state, so reset (which clears
  // state_q asynchronously) pulls dm_memWrite low immediately.
  always_comb begin
    dm_memRead   = ((state_q == ACCESS) && !we_q) || (state_q == RMW_RD);
    dm_memWrite  = ((state_q == ACCESS) && we_q) || (state_q == RMW_WR);
    dm_addr      = {addr_q[31:2], 2'b00};
    dm_writeData = (state_q == RMW_WR) ? store_word : wdata_q;
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_err   = a_err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign a_stall = a_req & ~a_ack_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata;
  logic        a_ack, a_err, a_stall;
  logic [31:0] a_rdata;
  logic        b_req, b_we;
  logic [31:0] b_addr, b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        dm_memRead, dm_memWrite;
  logic [31:0] dm_addr, dm_writeData, dm_readData;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_funct3     (a_funct3),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_ack        (a_ack),
    .a_err        (a_err),
    .a_rdata      (a_rdata),
    .a_stall      (a_stall),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_rdata      (b_rdata),
    .dm_memRead   (dm_memRead),
    .dm_memWrite  (dm_memWrite),
    .dm_addr      (dm_addr),
    .dm_writeData (dm_writeData),
    .dm_readData  (dm_readData)
  );

  // DM device: 256 words, combinational read, write on the clock edge.
  logic [31:0] tb_mem [256];
  assign dm_readData = tb_mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_memWrite) tb_mem[dm_addr[9:2]] <= dm_writeData;

  // Reference model: byte-level view of the same 256-word memory.
  logic [31:0] ref_mem [256];

  typedef struct {
    bit          own_b;
    bit          err;
    bit          chk;
    logic [31:0] rdata;
    int          exp_cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int errors = 0, checks = 0;
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, ack_cnt = 0, stall_lo_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [2:0] f3, input logic [31:0] addr);
    bit illegal;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return illegal || ((addr % acc_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    longint w, v, span;
    int sz, off;
    sz   = acc_size(f3);
    off  = addr % 4;
    w    = longint'(ref_mem[(addr / 4) % 256]);
    span = longint'(1) << (8 * sz);
    v    = (w >> (8 * off)) % span;
    if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int sz, off, idx, lane;
    logic [31:0] w;
    sz  = acc_size(f3);
    off = addr % 4;
    idx = (addr / 4) % 256;
    w   = ref_mem[idx];
    for (int i = 0; i < sz; i++) begin
      lane = off + i;
      w = (w & ~(32'hFF << (8 * lane))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * lane));
    end
    ref_mem[idx] = w;
  endtask

  // Monitor: counts DM strobes and pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (!rst) begin
      if (dm_memRead)  rd_cnt++;
      if (dm_memWrite) wr_cnt++;
      if (a_req && !a_stall) stall_lo_cnt++;
      if (a_ack || b_ack) begin
        ack_cnt++;
        check("single_ack", {31'd0, a_ack & b_ack}, 32'd0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b with no request pending", a_ack, b_ack);
        end else begin
          mon_e = sbq.pop_front();
          check({mon_e.name, "_owner_b"}, {31'd0, b_ack}, {31'd0, mon_e.own_b});
          if (!mon_e.own_b) check({mon_e.name, "_err"}, {31'd0, a_err}, {31'd0, mon_e.err});
          if (mon_e.chk) check({mon_e.name, "_rdata"}, mon_e.own_b ? b_rdata : a_rdata, mon_e.rdata);
          if (mon_e.exp_cyc >= 0) check({mon_e.name, "_ack_cycle"}, cyc, mon_e.exp_cyc);
        end
      end
    end
  end

  task automatic a_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input string nm);
    exp_t e;
    bit err;
    int lat, rd0, wr0, t, sz;
    err = model_err(f3, addr);
    sz  = acc_size(f3);
    e.own_b = 1'b0;
    e.err   = err;
    e.chk   = !we || err;
    e.rdata = (err || we) ? 32'h0 : model_load(f3, addr);
    e.name  = nm;
    lat = err ? 1 : (we && sz < 4) ? 3 : 2;
    if (!err && we) model_store(f3, addr, wdata);
    @(negedge clk); #1;
    e.exp_cyc = cyc + lat;
    sbq.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt;
    a_req = 1'b1; a_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wdata;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!a_ack && t < 20);
    a_req = 1'b0;
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no a_ack within %0d cycles", nm, t);
      sbq.delete();
    end else begin
      check({nm, "_dm_reads"}, rd_cnt - rd0, (err || (we && sz == 4)) ? 0 : 1);
      check({nm, "_dm_writes"}, wr_cnt - wr0, (err || !we) ? 0 : 1);
    end
  endtask

  task automatic b_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input string nm);
    exp_t e;
    int rd0, wr0, t;
    e.own_b = 1'b1;
    e.err   = 1'b0;
    e.chk   = !we;
    e.rdata = ref_mem[(addr / 4) % 256];
    e.name  = nm;
    if (we) ref_mem[(addr / 4) % 256] = wdata;
    @(negedge clk); #1;
    e.exp_cyc = cyc + 2;
    sbq.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt;
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    t = 0;
    do begin @(negedge clk); #1; t++; end while (!b_ack && t < 20);
    b_req = 1'b0;
    if (t >= 20) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no b_ack within %0d cycles", nm, t);
      sbq.delete();
    end else begin
      check({nm, "_dm_reads"}, rd_cnt - rd0, we ? 0 : 1);
      check({nm, "_dm_writes"}, wr_cnt - wr0, we ? 1 : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    exp_t e;
    int stall0, wr0, ack0;
    logic [2:0] f3_tbl [5];
    f3_tbl[0] = 3'd0; f3_tbl[1] = 3'd1; f3_tbl[2] = 3'd2; f3_tbl[3] = 3'd3; f3_tbl[4] = 3'd7;

    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      tb_mem[i] = w;
      ref_mem[i] = w;
    end
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_funct3 = 3'd0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ack", {31'd0, a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_a_err", {31'd0, a_err}, 32'd0);
    check("rst_a_rdata", a_rdata, 32'd0);
    check("rst_b_rdata", b_rdata, 32'd0);
    check("rst_dm_memRead", {31'd0, dm_memRead}, 32'd0);
    check("rst_dm_memWrite", {31'd0, dm_memWrite}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_writeData", dm_writeData, 32'd0);
    check("rst_a_stall_idle", {31'd0, a_stall}, 32'd0);
    a_req = 1'b1; #1;
    check("rst_a_stall_follows_req", {31'd0, a_stall}, 32'd1);
    a_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;

    // Fairness: both ports hold requests for six grants, A wins the first tie.
    for (int i = 0; i < 6; i++) begin
      e.own_b   = (i % 2) == 1;
      e.err     = 1'b0;
      e.chk     = 1'b1;
      e.rdata   = e.own_b ? ref_mem[32 + i / 2] : ref_mem[16 + i / 2];
      e.exp_cyc = -1;
      e.name    = e.own_b ? "fair_b" : "fair_a";
      sbq.push_back(e);
    end
    @(negedge clk); #1;
    stall0 = stall_lo_cnt;
    fork
      begin
        int t;
        a_req = 1'b1; a_we = 1'b0; a_funct3 = 3'd2; a_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
          t = 0;
          do begin @(negedge clk); #1; t++; end while (!a_ack && t < 40);
          if (t >= 40) begin
            checks++; errors++;
            $display("FAIL fair_a_timeout: grant %0d not acked", i);
          end
          if (i < 2) a_addr = 32'h44 + 32'(4 * i);
          else a_req = 1'b0;
        end
      end
      begin
        int t;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h80;
        for (int i = 0; i < 3; i++) begin
          t = 0;
          do begin @(negedge clk); #1; t++; end while (!b_ack && t < 40);
          if (t >= 40) begin
            checks++; errors++;
            $display("FAIL fair_b_timeout: grant %0d not acked", i);
          end
          if (i < 2) b_addr = 32'h84 + 32'(4 * i);
          else b_req = 1'b0;
        end
      end
    join
    check("fair_a_stall_low_cycles", stall_lo_cnt - stall0, 32'd3);
    check("fair_all_popped", sbq.size(), 32'd0);
    sbq.delete();

    // Word round trip, then byte store and sub-word loads
    a_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
    a_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_10");
    a_op(1'b1, 3'd0, 32'h11, 32'h000000AA, "sb_11");
    a_op(1'b0, 3'd0, 32'h11, 32'h0, "lb_11");
    a_op(1'b0, 3'd4, 32'h11, 32'h0, "lbu_11");
    a_op(1'b0, 3'd1, 32'h12, 32'h0, "lh_12");
    a_op(1'b0, 3'd5, 32'h12, 32'h0, "lhu_12");
    a_op(1'b1, 3'd1, 32'h12, 32'h00001234, "sh_12");
    a_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_10_after_sh");

    // Errors
    a_op(1'b0, 3'd2, 32'h12, 32'h0, "lw_misaligned");
    a_op(1'b0, 3'd3, 32'h10, 32'h0, "f3_011");
    a_op(1'b1, 3'd1, 32'h13, 32'h5555, "sh_misaligned");
    a_op(1'b0, 3'd2, 32'h10, 32'h0, "lw_10_after_errs");

    // Loader port, aliasing above 0x400
    b_op(1'b1, 32'h00000403, 32'hCAFEF00D, "b_sw_alias");
    b_op(1'b0, 32'h00000000, 32'h0, "b_lw_0");
    a_op(1'b0, 3'd1, 32'h2, 32'h0, "lh_2_via_alias");

    // Reset in the middle of a read-modify-write
    @(negedge clk); #1;
    wr0 = wr_cnt; ack0 = ack_cnt;
    a_req = 1'b1; a_we = 1'b1; a_funct3 = 3'd0; a_addr = 32'h20; a_wdata = 32'h00000055;
    @(negedge clk); #1;
    check("rmw_rd_reading", {31'd0, dm_memRead}, 32'd1);
    rst = 1'b1; #1;
    check("rmw_rst_no_write", {31'd0, dm_memWrite}, 32'd0);
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rmw_rst_writes", wr_cnt - wr0, 32'd0);
    check("rmw_rst_acks", ack_cnt - ack0, 32'd0);
    a_op(1'b0, 3'd2, 32'h20, 32'h0, "lw_20_after_rst");

    // Randomized mix on both ports
    for (int n = 0; n < 80; n++) begin
      logic [31:0] addr;
      logic [2:0]  f3;
      bit          we;
      addr = 32'(($urandom % 16) * 4 + ($urandom % 4));
      if (($urandom % 8) == 0) addr = addr + 32'h400;
      we = $urandom % 2;
      if (($urandom % 4) == 0) begin
        b_op(we, addr, $urandom, "rnd_b");
      end else begin
        f3 = we ? f3_tbl[$urandom % 5] : 3'($urandom % 8);
        a_op(we, f3, addr, $urandom, "rnd_a");
      end
    end

    repeat (3) @(negedge clk);
    check("end_scoreboard_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
